// File: rtl/stopwatch_controller.sv
// Stopwatch control and timekeeping core: button conditioning, run/pause/alarm
// sequencing, BCD time count with lap freeze, and display scan/blink strobes.
module stopwatch_controller #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop_btn_in,
  input  logic       clear_btn_in,
  input  logic       lap_btn_in,
  output logic [3:0] ms_bcd_tens_out,
  output logic [3:0] ms_bcd_ones_out,
  output logic [3:0] sec_bcd_tens_out,
  output logic [3:0] sec_bcd_ones_out,
  output logic       min_out,
  output logic       alarm_active_out,
  output logic       scan_clk_enable_out,
  output logic       blink_clk_enable_out,
  output logic [1:0] state_out,
  output logic       lap_hold_out
);

  // state | meaning
  // IDLE  | stopped at 0:00.00, waiting for start
  // RUN   | counting ticks
  // PAUSE | count and prescaler held
  // ALARM | reached 1:59.99, only clear leaves
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_ALARM = 2'b11} state_t;

  localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
  localparam logic [16:0]        TIME_MAX  = {1'b1, 4'd5, 4'd9, 4'd9, 4'd9};

  state_t state_q, state_d;

  // Button bits: [0] start_stop, [1] clear, [2] lap
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, pulse_q, pulse_d;
  logic       clr_p, ss_p, lap_p;

  // Time layout: {min, sec_tens, sec_ones, ms_tens, ms_ones}
  logic [16:0] time_q, time_d, lap_q, lap_d, disp_q, disp_d;
  logic        hold_q, hold_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic        scan_en_q, scan_en_d, blink_en_q, blink_en_d;
  logic        tick, at_max;

  function automatic logic [16:0] bcd_inc(input logic [16:0] t);
    logic [16:0] r;
    r = t;
    if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (t[7:4] != 4'd9) r[7:4] = t[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
        else begin
          r[11:8] = 4'd0;
          if (t[15:12] != 4'd5) r[15:12] = t[15:12] + 4'd1;
          else begin
            r[15:12] = 4'd0;
            r[16]    = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    sync1_d = {lap_btn_in, clear_btn_in, start_stop_btn_in};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
    clr_p   = pulse_q[1];
    ss_p    = pulse_q[0] & ~clr_p;
    lap_p   = pulse_q[2] & ~pulse_q[0] & ~clr_p;
    at_max  = (time_q == TIME_MAX);
    tick    = (state_q == S_RUN) && (tick_cnt_q == TICK_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ss_p) state_d = S_RUN;
      S_RUN: begin
        if (clr_p)               state_d = S_IDLE;
        else if (tick && at_max) state_d = S_ALARM;
        else if (ss_p)           state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (clr_p)     state_d = S_IDLE;
        else if (ss_p) state_d = S_RUN;
      end
      S_ALARM: if (clr_p) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    state_out        = state_q;
    alarm_active_out = (state_q == S_ALARM);
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (state_q == S_IDLE && state_d == S_RUN) tick_cnt_d = '0;
    else if (state_q == S_RUN) tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    time_d = time_q;
    if (clr_p)                time_d = '0;
    else if (tick && !at_max) time_d = bcd_inc(time_q);

    hold_d = hold_q;
    lap_d  = lap_q;
    if (lap_p && state_q == S_RUN && !hold_q) begin
      lap_d  = time_q;
      hold_d = 1'b1;
    end else if (lap_p && hold_q && (state_q == S_RUN || state_q == S_PAUSE)) begin
      hold_d = 1'b0;
    end
    if (state_d == S_IDLE || state_d == S_ALARM) hold_d = 1'b0;

    disp_d = hold_q ? lap_q : time_q;

    scan_en_d  = (scan_cnt_q == SCAN_MAX);
    scan_cnt_d = scan_en_d ? '0 : scan_cnt_q + 1'b1;

    // Restart the blink phase on alarm entry so the first blink is a full period away
    if (state_d == S_ALARM && state_q != S_ALARM) begin
      blink_en_d  = 1'b0;
      blink_cnt_d = '0;
    end else begin
      blink_en_d  = (blink_cnt_q == BLINK_MAX);
      blink_cnt_d = blink_en_d ? '0 : blink_cnt_q + 1'b1;
    end
  end

  // Synchronizers reset high so a button held through reset release is not seen as a press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      prev_q      <= '1;
      pulse_q     <= '0;
      time_q      <= '0;
      lap_q       <= '0;
      disp_q      <= '0;
      hold_q      <= 1'b0;
      tick_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      scan_en_q   <= 1'b0;
      blink_en_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      pulse_q     <= pulse_d;
      time_q      <= time_d;
      lap_q       <= lap_d;
      disp_q      <= disp_d;
      hold_q      <= hold_d;
      tick_cnt_q  <= tick_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      scan_en_q   <= scan_en_d;
      blink_en_q  <= blink_en_d;
    end
  end

  assign min_out              = disp_q[16];
  assign sec_bcd_tens_out     = disp_q[15:12];
  assign sec_bcd_ones_out     = disp_q[11:8];
  assign ms_bcd_tens_out      = disp_q[7:4];
  assign ms_bcd_ones_out      = disp_q[3:0];
  assign lap_hold_out         = hold_q;
  assign scan_clk_enable_out  = scan_en_q;
  assign blink_clk_enable_out = blink_en_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Testbench for stopwatch_controller: scenario tasks compared against a
// centisecond-based reference model of the stopwatch.
module tb_stopwatch_controller;
  localparam int TICK_DIV  = 4;
  localparam int SCAN_DIV  = 3;
  localparam int BLINK_DIV = 8;
  localparam int MAX_CS    = 11999;

  logic clk, reset_n, ss, clr, lap;
  logic [3:0] ms_t, ms_o, s_t, s_o;
  logic min_o, alarm_o, scan_o, blink_o, hold_o;
  logic [1:0] state_o;

  stopwatch_controller #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .start_stop_btn_in(ss), .clear_btn_in(clr), .lap_btn_in(lap),
    .ms_bcd_tens_out(ms_t), .ms_bcd_ones_out(ms_o),
    .sec_bcd_tens_out(s_t), .sec_bcd_ones_out(s_o),
    .min_out(min_o), .alarm_active_out(alarm_o),
    .scan_clk_enable_out(scan_o), .blink_clk_enable_out(blink_o),
    .state_out(state_o), .lap_hold_out(hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [22:0] dut_vec;
  assign dut_vec = {state_o, alarm_o, hold_o, scan_o, blink_o, min_o, s_t, s_o, ms_t, ms_o};

  // Reference model: time kept as centiseconds, state as 0 idle/1 run/2 pause/3 alarm
  int m_state, m_pre, m_cs, m_lap, m_disp, m_scan_cnt, m_blink_cnt;
  bit m_hold, m_scan, m_blink;
  bit [3:0] h_ss, h_clr, h_lap;
  bit p_ss, p_clr, p_lap, m_tick, n_hold;
  int n_state, n_pre, n_cs, n_lap;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_pre = 0; m_cs = 0; m_lap = 0; m_disp = 0;
      m_scan_cnt = 0; m_blink_cnt = 0; m_hold = 0; m_scan = 0; m_blink = 0;
      h_ss = 4'hf; h_clr = 4'hf; h_lap = 4'hf;
    end else begin
      // a press is acted on at the fourth edge after the level is first sampled
      p_clr = h_clr[2] & ~h_clr[3];
      p_ss  = h_ss[2] & ~h_ss[3] & ~p_clr;
      p_lap = h_lap[2] & ~h_lap[3] & ~p_clr & ~(h_ss[2] & ~h_ss[3]);
      h_ss  = {h_ss[2:0], ss};
      h_clr = {h_clr[2:0], clr};
      h_lap = {h_lap[2:0], lap};
      n_state = m_state; n_pre = m_pre; n_cs = m_cs; n_lap = m_lap; n_hold = m_hold;
      m_tick = (m_state == 1) && (m_pre == TICK_DIV - 1);
      if (m_state == 1) n_pre = m_tick ? 0 : m_pre + 1;
      if (p_clr) begin
        n_cs = 0;
        n_state = 0;
      end else begin
        case (m_state)
          0: if (p_ss) begin n_state = 1; n_pre = 0; end
          1: begin
            if (m_tick && m_cs == MAX_CS) n_state = 3;
            else begin
              if (m_tick) n_cs = m_cs + 1;
              if (p_ss) n_state = 2;
              else if (p_lap) begin
                if (!m_hold) begin n_lap = m_cs; n_hold = 1; end
                else n_hold = 0;
              end
            end
          end
          2: if (p_ss) n_state = 1; else if (p_lap && m_hold) n_hold = 0;
          default: ;
        endcase
      end
      if (n_state == 0 || n_state == 3) n_hold = 0;
      m_disp = m_hold ? m_lap : m_cs;
      if (m_scan_cnt == SCAN_DIV - 1) begin m_scan_cnt = 0; m_scan = 1; end
      else begin m_scan_cnt++; m_scan = 0; end
      if (n_state == 3 && m_state != 3) begin m_blink_cnt = 0; m_blink = 0; end
      else if (m_blink_cnt == BLINK_DIV - 1) begin m_blink_cnt = 0; m_blink = 1; end
      else begin m_blink_cnt++; m_blink = 0; end
      m_state = n_state; m_pre = n_pre; m_cs = n_cs; m_lap = n_lap; m_hold = n_hold;
    end
  end

  function automatic logic [22:0] exp_vec();
    int c;
    c = m_disp;
    return {2'(m_state), (m_state == 3), m_hold, m_scan, m_blink,
            1'(c / 6000), 4'((c / 1000) % 6), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic press(input int idx, input int hold_cycles);
    if (idx == 0) ss = 1'b1; else if (idx == 1) clr = 1'b1; else lap = 1'b1;
    repeat (hold_cycles) begin @(posedge clk); #1; end
    ss = 1'b0; clr = 1'b0; lap = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ss = 1'b1; clr = 1'b0; lap = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (dut_vec !== 23'd0) begin errors++; $display("FAIL reset_values got %h exp 0", dut_vec); end
    reset_n = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL idle_model got %h exp %h", dut_vec, exp_vec()); end
      checks++;
      if (scan_o !== ((cyc % SCAN_DIV) == 0)) begin errors++; $display("FAIL scan_phase cyc %0d got %b", cyc, scan_o); end
      checks++;
      if (blink_o !== ((cyc % BLINK_DIV) == 0)) begin errors++; $display("FAIL blink_phase cyc %0d got %b", cyc, blink_o); end
      checks++;
      if (state_o !== 2'b00) begin errors++; $display("FAIL held_btn_reset got state %b exp 00", state_o); end
    end
    ss = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic test_run();
    press(0, 1);
    for (int i = 0; i < 10 && state_o !== 2'b01; i++) begin @(posedge clk); #1; end
    checks++;
    if (state_o !== 2'b01) begin errors++; $display("FAIL run_entry got state %b exp 01", state_o); end
    repeat (41) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL run_model got %h exp %h", dut_vec, exp_vec()); end
    end
    checks++;
    if (dut_vec[16:0] !== {1'b0, 4'd0, 4'd0, 4'd1, 4'd0})
      begin errors++; $display("FAIL run_10_ticks got %h exp 00010", dut_vec[16:0]); end
  endtask

  task automatic test_rollover_alarm();
    bit seen10, seen60;
    int i;
    seen10 = 0; seen60 = 0;
    press(1, 2);
    repeat (6) begin @(posedge clk); #1; end
    press(0, 1);
    for (i = 0; i < 50000 && state_o !== 2'b11; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL count_model got %h exp %h", dut_vec, exp_vec()); end
      if (!seen10 && m_disp == 1000) begin
        seen10 = 1; checks++;
        if (dut_vec[16:0] !== {1'b0, 4'd1, 4'd0, 4'd0, 4'd0})
          begin errors++; $display("FAIL roll_10s got %h exp 01000", dut_vec[16:0]); end
      end
      if (!seen60 && m_disp == 6000) begin
        seen60 = 1; checks++;
        if (dut_vec[16:0] !== {1'b1, 4'd0, 4'd0, 4'd0, 4'd0})
          begin errors++; $display("FAIL roll_60s got %h exp 10000", dut_vec[16:0]); end
      end
    end
    checks++;
    if (!seen10 || !seen60 || state_o !== 2'b11)
      begin errors++; $display("FAIL alarm_reach got state %b seen %0d%0d exp 11", state_o, seen10, seen60); end
    checks++;
    if ({alarm_o, dut_vec[16:0]} !== {1'b1, 1'b1, 4'd5, 4'd9, 4'd9, 4'd9})
      begin errors++; $display("FAIL alarm_hold got %b %h exp 1 15999", alarm_o, dut_vec[16:0]); end
    for (int c = 1; c <= BLINK_DIV; c++) begin
      @(posedge clk); #1;
      checks++;
      if (blink_o !== (c == BLINK_DIV)) begin errors++; $display("FAIL alarm_blink cyc %0d got %b", c, blink_o); end
    end
    press(0, 1);
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL alarm_model got %h exp %h", dut_vec, exp_vec()); end
    end
    checks++;
    if (state_o !== 2'b11 || dut_vec[16:0] !== 17'h15999)
      begin errors++; $display("FAIL alarm_ignore_ss got %b %h exp 11 15999", state_o, dut_vec[16:0]); end
    press(1, 1);
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (state_o !== 2'b00 || alarm_o !== 1'b0 || dut_vec[16:0] !== 17'd0)
      begin errors++; $display("FAIL alarm_clear got %b %b %h exp 00 0 0", state_o, alarm_o, dut_vec[16:0]); end
  endtask

  task automatic test_lap();
    logic [16:0] v;
    press(2, 1);
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (hold_o !== 1'b0) begin errors++; $display("FAIL lap_idle got %b exp 0", hold_o); end
    press(0, 1);
    repeat (12 + $urandom_range(0, 8)) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL lap_pre got %h exp %h", dut_vec, exp_vec()); end
    end
    press(2, $urandom_range(1, 3));
    for (int i = 0; i < 10 && hold_o !== 1'b1; i++) begin @(posedge clk); #1; end
    checks++;
    if (hold_o !== 1'b1) begin errors++; $display("FAIL lap_set got %b exp 1", hold_o); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    v = dut_vec[16:0];
    repeat (30) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL lap_model got %h exp %h", dut_vec, exp_vec()); end
      checks++;
      if (dut_vec[16:0] !== v) begin errors++; $display("FAIL lap_frozen got %h exp %h", dut_vec[16:0], v); end
    end
    press(2, 1);
    for (int i = 0; i < 10 && hold_o !== 1'b0; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    checks++;
    if (dut_vec !== exp_vec() || dut_vec[16:0] === v)
      begin errors++; $display("FAIL lap_release got %h exp %h", dut_vec, exp_vec()); end
    press(2, 1);
    for (int i = 0; i < 10 && hold_o !== 1'b1; i++) begin @(posedge clk); #1; end
    press(0, 1);
    for (int i = 0; i < 10 && state_o !== 2'b10; i++) begin @(posedge clk); #1; end
    press(2, 1);
    for (int i = 0; i < 10 && hold_o !== 1'b0; i++) begin @(posedge clk); #1; end
    checks++;
    if (state_o !== 2'b10 || hold_o !== 1'b0 || dut_vec !== exp_vec())
      begin errors++; $display("FAIL lap_pause_release got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] v;
    press(0, 1);
    repeat (12) begin @(posedge clk); #1; end
    checks++;
    if (state_o !== 2'b01) begin errors++; $display("FAIL btb_run got %b exp 01", state_o); end
    ss = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    ss = 1'b0; clr = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (state_o !== 2'b00 || dut_vec[16:0] !== 17'd0)
      begin errors++; $display("FAIL btb_clear_wins got %b %h exp 00 0", state_o, dut_vec[16:0]); end
    press(0, 1);
    repeat ($urandom_range(10, 40)) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL btb_run_model got %h exp %h", dut_vec, exp_vec()); end
    end
    press(0, 1);
    for (int i = 0; i < 10 && state_o !== 2'b10; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    v = dut_vec[16:0];
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec[16:0] !== v || dut_vec !== exp_vec())
        begin errors++; $display("FAIL btb_pause_hold got %h exp %h", dut_vec, exp_vec()); end
    end
    press(0, 1);
    repeat (40) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL btb_resume got %h exp %h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) ss  = ~ss;
      if ($urandom_range(0, 15) == 0) clr = ~clr;
      if ($urandom_range(0, 7) == 0) lap = ~lap;
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_model got %h exp %h", dut_vec, exp_vec()); end
    end
    ss = 1'b0; clr = 1'b0; lap = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 23'd0) begin errors++; $display("FAIL mid_reset got %h exp 0", dut_vec); end
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL post_reset got %h exp %h", dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_rollover_alarm();
    test_lap();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
